// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with registered ALU inputs, a programmable settle time and a shared result bus.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int ALU_WAIT   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [DATA_WIDTH-1:0] OP1_0,
    input  logic [DATA_WIDTH-1:0] OP2_0,
    input  logic [OPRN_WIDTH-1:0] OPRN_0,
    input  logic                  REQ1,
    input  logic [DATA_WIDTH-1:0] OP1_1,
    input  logic [DATA_WIDTH-1:0] OP2_1,
    input  logic [OPRN_WIDTH-1:0] OPRN_1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  RES_ZERO,
    output logic                  RES_ERR,
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic [DATA_WIDTH-1:0] ALU_ZERO
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d, win_q, win_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  zero_q, zero_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] result_q, result_d, op1_q, op1_d, op2_q, op2_d;
    logic [OPRN_WIDTH-1:0] oprn_q, oprn_d;
    logic                  sel, legal;
    logic [OPRN_WIDTH-1:0] sel_oprn;
    logic                  unused_zero;

    // requester 1 wins when alone, or when both ask and the pointer favours it
    assign sel         = REQ1 & (~REQ0 | ptr_q);
    assign sel_oprn    = sel ? OPRN_1 : OPRN_0;
    assign legal       = (sel_oprn != '0) && (sel_oprn <= OPRN_WIDTH'(9));
    assign unused_zero = ^ALU_ZERO[DATA_WIDTH-1:1];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        oprn_d   = oprn_q;
        case (state_q)
            IDLE: if (REQ0 || REQ1) begin
                win_d    = sel;
                op1_d    = sel ? OP1_1 : OP1_0;
                op2_d    = sel ? OP2_1 : OP2_0;
                oprn_d   = sel_oprn;
                cnt_d    = 4'(ALU_WAIT - 1);
                state_d  = legal ? EXEC : DONE;
                result_d = legal ? result_q : '0;
                zero_d   = legal & zero_q;
                err_d    = ~legal | err_q;
                ack0_d   = ~legal & ~sel;
                ack1_d   = ~legal & sel;
            end
            EXEC: begin
                cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    result_d = ALU_OUT;
                    zero_d   = ALU_ZERO[0];
                    err_d    = 1'b0;
                    state_d  = DONE;
                    ack0_d   = ~win_q;
                    ack1_d   = win_q;
                end
            end
            DONE: begin
                ptr_d   = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            win_q    <= 1'b0;
            cnt_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            oprn_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            oprn_q   <= oprn_d;
        end
    end

    assign ACK0     = ack0_q;
    assign ACK1     = ack1_q;
    assign RESULT   = result_q;
    assign RES_ZERO = zero_q;
    assign RES_ERR  = err_q;
    assign ALU_OP1  = op1_q;
    assign ALU_OP2  = op2_q;
    assign ALU_OPRN = oprn_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table, hand sequences and randomized traffic against two
// arbiter instances (settle time 1 and 4), each driving its own model ALU.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int OW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel4 = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [DW-1:0] op1_0 = '0, op2_0 = '0, op1_1 = '0, op2_1 = '0;
    logic [OW-1:0] oprn_0 = '0, oprn_1 = '0;

    logic          a_ack0, a_ack1, a_zero, a_err, b_ack0, b_ack1, b_zero, b_err;
    logic [DW-1:0] a_res, a_op1, a_op2, a_out, a_zw, b_res, b_op1, b_op2, b_out, b_zw;
    logic [OW-1:0] a_oprn, b_oprn;

    // environment ALU; illegal opcodes produce garbage that must never reach RESULT
    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, b, input logic [OW-1:0] op);
        case (op)
            6'd1: return a + b;
            6'd2: return a - b;
            6'd3: return a * b;
            6'd4: return a >> b[4:0];
            6'd5: return a << b[4:0];
            6'd6: return a & b;
            6'd7: return a | b;
            6'd8: return a ^ b;
            6'd9: return ~(a | b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign a_out = alu_f(a_op1, a_op2, a_oprn);
    assign a_zw  = {31'b0, a_out == '0};
    assign b_out = alu_f(b_op1, b_op2, b_oprn);
    assign b_zw  = {31'b0, b_out == '0};

    alu_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .ALU_WAIT(1)) u1 (
        .CLK(clk), .RST(rst_n),
        .REQ0(req0 & ~sel4), .OP1_0(op1_0), .OP2_0(op2_0), .OPRN_0(oprn_0),
        .REQ1(req1 & ~sel4), .OP1_1(op1_1), .OP2_1(op2_1), .OPRN_1(oprn_1),
        .ACK0(a_ack0), .ACK1(a_ack1), .RESULT(a_res), .RES_ZERO(a_zero), .RES_ERR(a_err),
        .ALU_OP1(a_op1), .ALU_OP2(a_op2), .ALU_OPRN(a_oprn), .ALU_OUT(a_out), .ALU_ZERO(a_zw)
    );

    alu_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW), .ALU_WAIT(4)) u4 (
        .CLK(clk), .RST(rst_n),
        .REQ0(req0 & sel4), .OP1_0(op1_0), .OP2_0(op2_0), .OPRN_0(oprn_0),
        .REQ1(req1 & sel4), .OP1_1(op1_1), .OP2_1(op2_1), .OPRN_1(oprn_1),
        .ACK0(b_ack0), .ACK1(b_ack1), .RESULT(b_res), .RES_ZERO(b_zero), .RES_ERR(b_err),
        .ALU_OP1(b_op1), .ALU_OP2(b_op2), .ALU_OPRN(b_oprn), .ALU_OUT(b_out), .ALU_ZERO(b_zw)
    );

    logic          ack0, ack1, zero, err;
    logic [DW-1:0] res, op1, op2;
    logic [OW-1:0] oprn;
    assign ack0 = sel4 ? b_ack0 : a_ack0;
    assign ack1 = sel4 ? b_ack1 : a_ack1;
    assign zero = sel4 ? b_zero : a_zero;
    assign err  = sel4 ? b_err  : a_err;
    assign res  = sel4 ? b_res  : a_res;
    assign op1  = sel4 ? b_op1  : a_op1;
    assign op2  = sel4 ? b_op2  : a_op2;
    assign oprn = sel4 ? b_oprn : a_oprn;

    int    checks = 0;
    int    errors = 0;
    string tag = "init";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s actual=%0h required=%0h", tag, name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ack", {ack1, ack0}, 0);
        chk("rst_res", {zero, err, res}, 0);
        chk("rst_alu", {oprn, op1 | op2}, 0);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic who, input logic [DW-1:0] a, b, input logic [OW-1:0] op);
        if (who) begin op1_1 = a; op2_1 = b; oprn_1 = op; req1 = 1'b1; end
        else     begin op1_0 = a; op2_0 = b; oprn_0 = op; req0 = 1'b1; end
    endtask

    task automatic run_one(input logic who, input logic [DW-1:0] a, b, input logic [OW-1:0] op,
                           input logic [DW-1:0] er, input logic ez, ee, input int el);
        int n;
        @(negedge clk);
        drive(who, a, b, op);
        n = 1;
        while (!(ack0 || ack1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, el);
        chk("ack_who", {ack1, ack0}, who ? 2'b10 : 2'b01);
        chk("result", res, er);
        chk("zero", zero, ez);
        chk("err", err, ee);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("ack_pulse", {ack1, ack0}, 0);
        chk("result_hold", {zero, err, res}, {ez, ee, er});
    endtask

    typedef struct {
        logic          who;
        logic [DW-1:0] a, b;
        logic [OW-1:0] op;
        logic [DW-1:0] er;
        logic          ez, ee;
    } vec_t;

    task automatic rand_phase(input int cycles);
        logic          pend[2], just[2];
        int            rise[2];
        logic [DW-1:0] x1[2], x2[2], er;
        logic [OW-1:0] xo[2];
        logic          lg, viol;
        int            cyc, last_ack, last_win;
        cyc = 0; last_ack = 1; last_win = 1;
        pend = '{1'b0, 1'b0};
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            cyc++;
            just = '{1'b0, 1'b0};
            if (ack0 || ack1) chk("dual_ack", ack0 & ack1, 0);
            for (int i = 0; i < 2; i++) begin
                if (i == 1 ? ack1 : ack0) begin
                    lg = xo[i] >= 6'd1 && xo[i] <= 6'd9;
                    er = lg ? alu_f(x1[i], x2[i], xo[i]) : '0;
                    chk("rand_pending", pend[i], 1);
                    chk("rand_result", res, er);
                    chk("rand_flags", {zero, err}, {lg && er == '0, !lg});
                    viol = pend[1-i] && rise[1-i] <= last_ack && last_win == i;
                    chk("rr_fair", viol, 0);
                    pend[i] = 1'b0; just[i] = 1'b1; last_ack = cyc; last_win = i;
                    if (i == 1) req1 = 1'b0; else req0 = 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && cyc - rise[i] > 40) begin
                    chk("starve_cycles", cyc - rise[i], 40);
                    pend[i] = 1'b0;
                    if (i == 1) req1 = 1'b0; else req0 = 1'b0;
                end
                if (!pend[i] && !just[i] && $urandom_range(0, 2) == 0) begin
                    x1[i] = $urandom; x2[i] = $urandom_range(0, 3) == 0 ? x1[i] : $urandom;
                    xo[i] = 6'($urandom_range(0, 11));
                    drive(i[0], x1[i], x2[i], xo[i]);
                    pend[i] = 1'b1; rise[i] = cyc;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    vec_t vecs[14];
    int   n, k;
    logic order[4];
    logic again[2];

    initial begin
        vecs[0]  = '{0, 5, 7, 1, 12, 0, 0};
        vecs[1]  = '{1, 9, 9, 2, 0, 1, 0};
        vecs[2]  = '{0, 1, 2, 10, 0, 0, 1};
        vecs[3]  = '{0, 3, 4, 3, 12, 0, 0};
        vecs[4]  = '{1, 7, 7, 0, 0, 0, 1};
        vecs[5]  = '{1, 32'hFFFF_FFFF, 1, 1, 0, 1, 0};
        vecs[6]  = '{0, 8, 2, 4, 2, 0, 0};
        vecs[7]  = '{1, 1, 31, 5, 32'h8000_0000, 0, 0};
        vecs[8]  = '{0, 32'hF0F0, 32'h0FF0, 6, 32'h00F0, 0, 0};
        vecs[9]  = '{1, 1, 2, 7, 3, 0, 0};
        vecs[10] = '{0, 5, 5, 8, 0, 1, 0};
        vecs[11] = '{1, 0, 0, 9, 32'hFFFF_FFFF, 0, 0};
        vecs[12] = '{0, 1, 1, 63, 0, 0, 1};
        vecs[13] = '{1, 2, 3, 3, 6, 0, 0};

        tag = "reset";
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tag = $sformatf("vec%0d", i);
            run_one(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].op,
                    vecs[i].er, vecs[i].ez, vecs[i].ee, vecs[i].ee ? 2 : 3);
        end

        tag = "both";
        do_reset();
        @(negedge clk);
        drive(0, 32'hF0F0, 32'h0FF0, 6);
        drive(1, 1, 2, 7);
        k = 0; again = '{1'b0, 1'b0};
        for (int c = 0; c < 100 && k < 4; c++) begin
            @(negedge clk);
            if (again[0]) req0 = 1'b1;
            if (again[1]) req1 = 1'b1;
            again = '{1'b0, 1'b0};
            if (ack0 || ack1) begin
                chk("no_dual", ack0 & ack1, 0);
                order[k] = ack1;
                chk("both_res", res, ack1 ? 32'h3 : 32'h00F0);
                if (ack1) begin req1 = 1'b0; again[1] = 1'b1; end
                else      begin req0 = 1'b0; again[0] = 1'b1; end
                k++;
            end
        end
        chk("grants", k, 4);
        for (int i = 0; i < k; i++) chk($sformatf("order%0d", i), order[i], i % 2);
        req0 = 1'b0; req1 = 1'b0;

        tag = "wait4";
        sel4 = 1'b1;
        do_reset();
        @(negedge clk);
        drive(0, 3, 4, 3);
        n = 1;
        repeat (4) begin
            @(negedge clk);
            n++;
            chk("hold_alu", {oprn, op1, op2}, {6'd3, 32'd3, 32'd4});
            chk("no_early_ack", {ack1, ack0}, 0);
            if (n == 3) op1_0 = 99;
        end
        @(negedge clk);
        chk("ack6", {ack1, ack0}, 2'b01);
        chk("res12", res, 12);
        req0 = 1'b0;
        @(negedge clk);
        chk("ack6_pulse", {ack1, ack0}, 0);

        tag = "rst_exec";
        @(negedge clk);
        drive(0, 5, 7, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_clear", {ack0, ack1, zero, err, oprn, res | op1 | op2}, 0);
        req0 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no_ack_rst", {ack1, ack0}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 1, 2, 7);
        drive(0, 32'hF0F0, 32'h0FF0, 6);
        n = 0;
        while (!(ack0 || ack1) && n < 40) begin @(negedge clk); n++; end
        chk("ptr_reset_first", {ack1, ack0}, 2'b01);
        chk("first_res", res, 32'h00F0);
        req0 = 1'b0;
        @(negedge clk);
        n = 0;
        while (!(ack0 || ack1) && n < 40) begin @(negedge clk); n++; end
        chk("then_req1", {ack1, ack0}, 2'b10);
        chk("then_res", res, 3);
        req1 = 1'b0;

        tag = "rand1";
        sel4 = 1'b0;
        do_reset();
        rand_phase(1500);
        tag = "rand4";
        sel4 = 1'b1;
        do_reset();
        rand_phase(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 32-bit combinational ALU between two requesters (e.g. control unit and address-generation logic).
- Arbitration is round-robin; each requester uses a level REQ and a one-cycle ACK handshake.
- Operands and opcode are registered onto the ALU inputs, and the ALU output is sampled after a programmable settle time.
- The result and ZERO/error status are returned on a shared result bus.

Parameters:
DATA_WIDTH, 32, operand/result width
OPRN_WIDTH, 6, ALU operation code width
ALU_WAIT, 1, cycles the ALU inputs are held stable before the result is sampled (1..15)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset; asynchronous, active-low
REQ0  input  1  requester 0 request (level)
OP1_0  input  DATA_WIDTH  requester 0 operand 1
OP2_0  input  DATA_WIDTH  requester 0 operand 2
OPRN_0  input  OPRN_WIDTH  requester 0 opcode
REQ1  input  1  requester 1 request (level)
OP1_1  input  DATA_WIDTH  requester 1 operand 1
OP2_1  input  DATA_WIDTH  requester 1 operand 2
OPRN_1  input  OPRN_WIDTH  requester 1 opcode
ACK0  output  1  one-cycle completion pulse to requester 0
ACK1  output  1  one-cycle completion pulse to requester 1
RESULT  output  DATA_WIDTH  result of the last completed operation
RES_ZERO  output  1  last result was zero
RES_ERR  output  1  last opcode was illegal
ALU_OP1  output  DATA_WIDTH  to ALU OP1
ALU_OP2  output  DATA_WIDTH  to ALU OP2
ALU_OPRN  output  OPRN_WIDTH  to ALU OPRN
ALU_OUT  input  DATA_WIDTH  from ALU OUT
ALU_ZERO  input  DATA_WIDTH  from ALU ZERO; value is 0 or 1, only bit 0 is used

Behaviour:
Reset (RST low, asynchronous):
- State goes to IDLE.
- ACK0, ACK1, RESULT, RES_ZERO, RES_ERR, ALU_OP1, ALU_OP2 and ALU_OPRN go to 0.
- Round-robin pointer goes to 0, wait counter goes to 0.

State machine (states IDLE, EXEC, DONE):
- IDLE, no REQ: stay in IDLE. ALU_* registers hold their last values.
- IDLE, any REQ: the winner is the sole requester, or the pointer's requester if both request.
  - Latch the winner's OP1/OP2/OPRN into ALU_OP1/ALU_OP2/ALU_OPRN and record the winner ID.
  - Legal opcode (1..9): counter = ALU_WAIT-1, go to EXEC.
  - Illegal opcode (0 or >9): go directly to DONE with RESULT=0, RES_ZERO=0, RES_ERR=1.
- EXEC, counter != 0: decrement the counter.
- EXEC, counter == 0: capture RESULT=ALU_OUT, RES_ZERO=ALU_ZERO[0], RES_ERR=0; go to DONE.
- DONE: the winner's ACK is high for exactly this one cycle. On exit, the pointer moves to the non-winner and the state goes to IDLE.

Timing and handshake:
- Latency, REQ sampled high to ACK high: ALU_WAIT+2 cycles for legal opcodes, 2 cycles for illegal ones.
- A requester holds REQ and its operands stable until it sees ACK, then drops REQ at the next edge.
- If REQ is still high in the IDLE cycle after ACK, it is a new request.
- Minimum 1 IDLE cycle between consecutive grants.
- ACK0 and ACK1 are never high together.
- The non-winner's request is ignored during EXEC/DONE, is not lost, and wins the next IDLE arbitration.
- RESULT, RES_ZERO and RES_ERR stay valid from ACK until the next capture.

Boundary conditions:
- Operand changes during EXEC/DONE have no effect, since the latched values are used.
- Reset mid-EXEC/DONE aborts the operation with no ACK; the requester must re-request.
- ALU_WAIT=1: EXEC lasts exactly one cycle.
- Output x from the ALU is never sampled for legal opcodes, because the ALU inputs have been stable for ALU_WAIT cycles.

Test Plan:
1. ALU_WAIT=1; REQ0 with 5 + 7, OPRN=0x01 -> ACK0 pulses 3 cycles after REQ is sampled; RESULT=12, RES_ZERO=0, RES_ERR=0; ACK1 stays 0.
2. REQ1 with 9 - 9, OPRN=0x02 -> ACK1 pulses; RESULT=0, RES_ZERO=1.
3. REQ0 and REQ1 both held continuously with different ops (0x06 AND on 0xF0F0, 0x0FF0; 0x07 OR on 0x1, 0x2), released after each ACK and reasserted -> grant order 0,1,0,1; RESULT=0x00F0 with ACK0 and 0x3 with ACK1; never simultaneous ACKs.
4. REQ0 with OPRN=0x0A -> ACK0 2 cycles after sampling; RES_ERR=1, RESULT=0, RES_ZERO=0; a following legal op clears RES_ERR.
5. ALU_WAIT=4; REQ0 with 3 * 4, OPRN=0x03 -> ACK0 at cycle 6; ALU_OP1/ALU_OP2/ALU_OPRN stable for all 4 EXEC cycles even though OP1_0 changes mid-op; RESULT=12.
6. Assert RST low during EXEC -> all outputs 0 immediately, with no ACK. After release, REQ1 alone is granted, and with both requesting, requester 0 wins first (pointer reset).
